// File: rtl/eth_phy_10g_tx_hdr_err_inject_if.sv
// 64b/66b block bus into and out of the TX sync-header error injector.
// The master drives the raw PHY blocks and observes what goes to the serdes.
interface eth_phy_10g_tx_hdr_err_inject_if #(
  parameter int DATA_WIDTH = 64,
  parameter int HDR_WIDTH  = 2
);
  logic [DATA_WIDTH-1:0] in_data;
  logic [HDR_WIDTH-1:0]  in_hdr;
  logic [DATA_WIDTH-1:0] out_data;
  logic [HDR_WIDTH-1:0]  out_hdr;

  modport master (output in_data, output in_hdr, input out_data, input out_hdr);
  modport slave  (input in_data, input in_hdr, output out_data, output out_hdr);
endinterface

// File: rtl/eth_phy_10g_tx_hdr_err_inject.sv
// Registered TX block pass-through that replaces the sync header of a
// scheduled series of blocks with an invalid value.
//
// state  | meaning
// IDLE   | no run; waiting for cfg_start
// DELAY  | passing cfg_delay clean blocks before the first bad header
// INJECT | current block's header is replaced by the bad header
// GAP    | passing cfg_spacing clean blocks between bad headers
module eth_phy_10g_tx_hdr_err_inject #(
  parameter int DATA_WIDTH = 64,
  parameter int HDR_WIDTH  = 2,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 tx_clk,
  input  logic                 tx_rst,
  eth_phy_10g_tx_hdr_err_inject_if.slave blk,
  input  logic                 cfg_start,
  input  logic                 cfg_abort,
  input  logic [15:0]          cfg_delay,
  input  logic [CNT_WIDTH-1:0] cfg_count,
  input  logic [7:0]           cfg_spacing,
  input  logic [HDR_WIDTH-1:0] cfg_bad_hdr,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] inj_count
);

  typedef enum logic [1:0] {IDLE, DELAY, INJECT, GAP} state_t;

  state_t                state;
  logic [15:0]           dly_cnt;
  logic [7:0]            gap_cnt;
  logic [CNT_WIDTH-1:0]  rem_cnt;
  logic [7:0]            spacing_l;
  logic [HDR_WIDTH-1:0]  bad_hdr_l;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [HDR_WIDTH-1:0]  out_hdr_q;

  assign blk.out_data = out_data_q;
  assign blk.out_hdr  = out_hdr_q;

  always_ff @(posedge tx_clk) begin
    if (tx_rst) begin
      state      <= IDLE;
      dly_cnt    <= '0;
      gap_cnt    <= '0;
      rem_cnt    <= '0;
      spacing_l  <= '0;
      bad_hdr_l  <= '0;
      out_data_q <= '0;
      out_hdr_q  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      inj_count  <= '0;
    end else begin
      out_data_q <= blk.in_data;
      out_hdr_q  <= (state == INJECT) ? bad_hdr_l : blk.in_hdr;
      done       <= 1'b0;
      if (state == INJECT) begin
        inj_count <= inj_count + 1'b1;
        rem_cnt   <= rem_cnt - 1'b1;
      end
      // abort overrides every transition, including a start in IDLE
      if (cfg_abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cfg_start) begin
              spacing_l <= cfg_spacing;
              // only all-zeros or all-ones are invalid headers; 01/10 fold to zeros
              bad_hdr_l <= (cfg_bad_hdr == {HDR_WIDTH{1'b1}}) ? {HDR_WIDTH{1'b1}} : '0;
              rem_cnt   <= cfg_count;
              dly_cnt   <= cfg_delay;
              inj_count <= '0;
              if (cfg_count == '0) begin
                done <= 1'b1;
              end else if (cfg_delay == 16'd0) begin
                state <= INJECT;
                busy  <= 1'b1;
              end else begin
                state <= DELAY;
                busy  <= 1'b1;
              end
            end
          end
          DELAY: begin
            if (dly_cnt == 16'd1) state <= INJECT;
            else dly_cnt <= dly_cnt - 16'd1;
          end
          INJECT: begin
            if (rem_cnt == CNT_WIDTH'(1)) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (spacing_l != 8'd0) begin
              state   <= GAP;
              gap_cnt <= spacing_l;
            end
          end
          GAP: begin
            if (gap_cnt == 8'd1) state <= INJECT;
            else gap_cnt <= gap_cnt - 8'd1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eth_phy_10g_tx_hdr_err_inject.sv
// Randomized bench for the TX header error injector; expected outputs come
// from a per-cycle schedule computed from the injection timing formula.
module tb_eth_phy_10g_tx_hdr_err_inject;
  localparam int N = 8192;

  logic       tx_clk = 1'b0;
  logic       tx_rst;
  logic       cfg_start, cfg_abort;
  logic [15:0] cfg_delay;
  logic [7:0] cfg_count, cfg_spacing;
  logic [1:0] cfg_bad_hdr;
  logic       busy, done;
  logic [7:0] inj_count;

  eth_phy_10g_tx_hdr_err_inject_if #(.DATA_WIDTH(64), .HDR_WIDTH(2)) bif ();

  eth_phy_10g_tx_hdr_err_inject #(.DATA_WIDTH(64), .HDR_WIDTH(2), .CNT_WIDTH(8)) dut (
    .tx_clk(tx_clk), .tx_rst(tx_rst), .blk(bif),
    .cfg_start(cfg_start), .cfg_abort(cfg_abort), .cfg_delay(cfg_delay),
    .cfg_count(cfg_count), .cfg_spacing(cfg_spacing), .cfg_bad_hdr(cfg_bad_hdr),
    .busy(busy), .done(done), .inj_count(inj_count)
  );

  always #5 tx_clk = ~tx_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int run_s, run_end;

  // input history and expected-event schedule, indexed by cycle number
  logic [63:0] h_data [N];
  logic [1:0]  h_hdr  [N];
  bit          h_rst  [N];
  bit          e_bad  [N];
  logic [1:0]  e_badv [N];
  bit          e_done [N];
  bit          e_busy [N];
  int          e_inj  [N];
  int          inj_run = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    h_rst[cyc] = tx_rst;
    @(posedge tx_clk);
    #1;
    cyc++;
    bif.in_data = {$urandom, $urandom};
    bif.in_hdr  = 2'($urandom_range(0, 3));
    h_data[cyc] = bif.in_data;
    h_hdr[cyc]  = bif.in_hdr;
  endtask

  task automatic idle_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic clear_from(input int a);
    for (int i = a; i < N; i++) begin
      e_bad[i] = 0; e_done[i] = 0; e_busy[i] = 0; e_inj[i] = -1;
    end
  endtask

  task automatic scramble_cfg();
    cfg_delay   = 16'($urandom);
    cfg_count   = 8'($urandom);
    cfg_spacing = 8'($urandom);
    cfg_bad_hdr = 2'($urandom);
  endtask

  // k-th bad header appears at S+D+2+(k-1)*(G+1); busy spans S+1 .. last bad - 1
  task automatic start_run(input int d, input int c, input int g, input logic [1:0] b);
    logic [1:0] bv;
    int t;
    bv = (b == 2'b11) ? 2'b11 : 2'b00;
    run_s = cyc;
    cfg_delay = 16'(d); cfg_count = 8'(c); cfg_spacing = 8'(g); cfg_bad_hdr = b;
    cfg_start = 1'b1;
    e_inj[run_s + 1] = 0;
    if (c == 0) begin
      e_done[run_s + 1] = 1;
      run_end = run_s + 1;
    end else begin
      run_end = run_s + d + 2 + (c - 1) * (g + 1);
      for (int i = run_s + 1; i < run_end; i++) e_busy[i] = 1;
      for (int k = 1; k <= c; k++) begin
        t = run_s + d + 2 + (k - 1) * (g + 1);
        e_bad[t] = 1; e_badv[t] = bv; e_inj[t] = k;
      end
      e_done[run_end] = 1;
    end
    tick();
    cfg_start = 1'b0;
    scramble_cfg();
  endtask

  task automatic do_abort();
    cfg_abort = 1'b1;
    clear_from(cyc + 1);
    tick();
    cfg_abort = 1'b0;
  endtask

  task automatic do_reset();
    tx_rst = 1'b1;
    clear_from(cyc + 1);
    tick();
    tx_rst = 1'b0;
  endtask

  task automatic stray_start();
    cfg_start = 1'b1;
    scramble_cfg();
    tick();
    cfg_start = 1'b0;
  endtask

  always @(negedge tx_clk) begin
    if (cyc >= 1) begin
      if (h_rst[cyc - 1]) begin
        inj_run = 0;
        check("rst_data", bif.out_data, 64'd0);
        check("rst_hdr",  64'(bif.out_hdr), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_inj",  64'(inj_count), 64'd0);
      end else begin
        if (e_inj[cyc] >= 0) inj_run = e_inj[cyc];
        check("data", bif.out_data, h_data[cyc - 1]);
        check("hdr",  64'(bif.out_hdr), 64'(e_bad[cyc] ? e_badv[cyc] : h_hdr[cyc - 1]));
        check("done", 64'(done), 64'(e_done[cyc]));
        check("busy", 64'(busy), 64'(e_busy[cyc]));
        check("inj",  64'(inj_count), 64'(inj_run));
      end
    end
  end

  initial begin
    int d, c, g, mode, t;
    logic [1:0] b;
    for (int i = 0; i < N; i++) begin
      e_bad[i] = 0; e_done[i] = 0; e_busy[i] = 0; e_inj[i] = -1; h_rst[i] = 0;
    end
    tx_rst = 1'b1;
    cfg_start = 1'b0; cfg_abort = 1'b0;
    cfg_delay = '0; cfg_count = '0; cfg_spacing = '0; cfg_bad_hdr = '0;
    bif.in_data = {$urandom, $urandom};
    bif.in_hdr  = 2'($urandom_range(0, 3));
    h_data[0] = bif.in_data;
    h_hdr[0]  = bif.in_hdr;
    repeat (3) tick();
    tx_rst = 1'b0;
    repeat (2) tick();

    start_run(0, 1, 0, 2'b00);       idle_until(run_end + 2);
    start_run(3, 4, 2, 2'b11);       idle_until(run_end + 2);
    start_run(5, 0, 1, 2'b11);       idle_until(run_end + 2);
    start_run(2, 2, 1, 2'b10);       idle_until(run_end + 2);

    // abort in 2nd GAP cycle, with an ignored second start earlier in the run
    start_run(2, 5, 3, 2'b11);
    stray_start();
    idle_until(run_s + 2 + 3);
    do_abort();
    repeat (3) tick();

    // abort and start together in IDLE: nothing should happen
    cfg_abort = 1'b1; cfg_start = 1'b1; cfg_count = 8'd3;
    tick();
    cfg_abort = 1'b0; cfg_start = 1'b0;
    repeat (3) tick();

    // reset in the middle of consecutive injections, then a normal run
    start_run(1, 4, 0, 2'b11);
    idle_until(run_s + 3);
    do_reset();
    repeat (2) tick();
    start_run(1, 2, 1, 2'b00);       idle_until(run_end + 2);

    for (int r = 0; r < 60; r++) begin
      d = $urandom_range(0, 6); c = $urandom_range(0, 5);
      g = $urandom_range(0, 3); b = 2'($urandom_range(0, 3));
      mode = $urandom_range(0, 3);
      start_run(d, c, g, b);
      if (c > 0 && run_end - 1 > run_s + 1) begin
        t = $urandom_range(run_s + 1, run_end - 1);
        if (mode == 1 && e_busy[t]) begin
          idle_until(t); stray_start();
        end else if (mode == 2 && e_busy[t] && !e_bad[t + 1]) begin
          idle_until(t); do_abort();
        end else if (mode == 3) begin
          idle_until(t); do_reset();
        end
      end
      idle_until(run_end + $urandom_range(1, 3));
    end

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
